mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port memory between instruction fetch (IF, read-only) and load/store (LS, read/write).
//  Sits between the fetch stage / LSU and the unified memory.
//  Allows one outstanding transaction, with LS priority and a starvation guard for IF.
//  Drops in-flight fetch responses on a pipeline redirect (taken branch/jump).
// PARAMETERS
//  XLEN            32  address/data width
//  MAX_LSU_STREAK  4   max consecutive LS grants while IF waits; must be >=1
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     synchronous, active-high reset
//  if_req     in   1     IF read request; held until if_gnt
//  if_addr    in   XLEN  IF address
//  if_flush   in   1     redirect: cancel pending/in-flight IF access
//  if_gnt     out  1     IF request accepted (1-cycle pulse)
//  if_rvalid  out  1     IF read data valid (1-cycle pulse)
//  if_rdata   out  XLEN  IF read data
//  ls_req     in   1     LS request; held until ls_gnt
//  ls_we      in   1     1 = store, 0 = load
//  ls_addr    in   XLEN  LS address
//  ls_wdata   in   XLEN  store data
//  ls_wstrb   in   4     store byte enables
//  ls_gnt     out  1     LS request accepted (1-cycle pulse)
//  ls_rvalid  out  1     load data valid / store ack (1-cycle pulse)
//  ls_rdata   out  XLEN  load data
//  mem_req    out  1     memory request, held until mem_ready
//  mem_we     out  1     memory write enable
//  mem_addr   out  XLEN  memory address
//  mem_wdata  out  XLEN  memory write data
//  mem_wstrb  out  4     memory byte enables
//  mem_ready  in   1     memory accepts request this cycle
//  mem_rvalid in   1     memory response (read data or write ack); never in the same cycle as mem_ready
//  mem_rdata  in   XLEN  memory read data
// BEHAVIOUR
//  FSM states:
//  - IDLE -> REQ: on any grant.
//  - REQ -> RESP: when mem_ready=1.
//  - RESP -> IDLE: when mem_rvalid=1.
//  Arbitration (IDLE only):
//  - Effective IF request = if_req & ~if_flush.
//  - If streak==MAX_LSU_STREAK and IF requests: grant IF. Otherwise LS wins over IF.
//  - Winner gets gnt in the same cycle (combinational from registered state + inputs).
//  - On grant, latch owner, addr, we, wdata, wstrb; IF grants latch we=0, wstrb=0.
//  - No grants in REQ/RESP; requesters keep req high.
//  Memory side:
//  - mem_req=1 only in REQ; mem_* fields come from the latched registers.
//  - mem_rvalid is ignored outside RESP.
//  Response routing (RESP):
//  - mem_rvalid drives owner's rvalid combinationally; rdata = mem_rdata.
//  - Non-owner rvalid=0; rdata outputs carry mem_rdata and are valid only when the matching rvalid=1.
//  - Minimum latency: gnt @T, mem_req @T+1, response earliest @T+2. Next grant earliest @T+3.
//  Flush:
//  - if_flush=1 while owner=IF in REQ or RESP sets drop.
//  - Transaction still completes on the memory side; if_rvalid is suppressed, including if flush coincides with mem_rvalid.
//  - drop clears on return to IDLE.
//  - if_flush has no effect on an LS-owned transaction.
//  Streak counter (width $clog2(MAX_LSU_STREAK+1)):
//  - +1 on an LS grant while if_req=1 (saturates at MAX).
//  - Clears on an IF grant, or on an LS grant with if_req=0.
//  Reset:
//  - state=IDLE; owner=LS; drop=0; streak=0; latched addr/wdata/wstrb/we=0.
//  - All gnt/rvalid/mem_req=0.
//  - Reset mid-transaction abandons it; a late mem_rvalid is then ignored (IDLE).
// TESTING
//  1. IF alone, if_addr=0x100, mem_ready same cycle as mem_req, mem_rvalid next cycle, rdata=0xDEADBEEF:
//     if_gnt @1, mem_req @2, if_rvalid=1 with if_rdata=0xDEADBEEF @3.
//  2. if_req and ls_req (store 0x200, wdata=0x12345678, wstrb=0xF) both rise together:
//     ls_gnt first; mem_we=1, mem_wstrb=0xF; ls_rvalid on ack; then if_gnt in the next IDLE cycle.
//  3. if_req held high, ls_req held high, MAX_LSU_STREAK=4:
//     grant order LS,LS,LS,LS,IF,LS,...; streak returns to 0 after the IF grant.
//  4. IF transaction in RESP, if_flush=1 one cycle before mem_rvalid:
//     if_rvalid stays 0; FSM returns to IDLE; next if_req is granted normally.
//  5. if_req=1 with if_flush=1 in IDLE, ls_req=0: no if_gnt that cycle. Then if_flush=0: if_gnt next cycle.
//  6. rst=1 while in REQ with mem_ready=0: mem_req=0 next cycle; a following mem_rvalid produces no if_rvalid or ls_rvalid.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (read-only) and load/store.
// One outstanding transaction, LS priority with a bounded streak, and fetch-response drop on redirect.
module mem_port_arbiter #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_flush,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  input  logic [3:0]      ls_wstrb,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned   SW         = $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
  typedef enum logic       {OWN_LS, OWN_IF}        owner_t;

  state_t          state, state_nxt;
  owner_t          owner;
  logic            drop;
  logic [SW-1:0]   streak;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [3:0]      wstrb_q;
  logic            we_q;
  logic            if_eff, if_win, ls_win;

  always_comb begin
    if_eff    = if_req & ~if_flush;
    if_win    = 1'b0;
    ls_win    = 1'b0;
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (if_eff && (streak == STREAK_MAX || !ls_req)) begin
          if_win = 1'b1;
        end else if (ls_req) begin
          ls_win = 1'b1;
        end
        if (if_win || ls_win) state_nxt = S_REQ;
      end
      S_REQ:   if (mem_ready)  state_nxt = S_RESP;
      S_RESP:  if (mem_rvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = if_win;
    ls_gnt    = ls_win;
    mem_req   = (state == S_REQ);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wstrb = wstrb_q;
    // A flush in the same cycle as the response must also suppress it, not just a registered drop.
    if_rvalid = (state == S_RESP) && (owner == OWN_IF) && mem_rvalid && !drop && !if_flush;
    ls_rvalid = (state == S_RESP) && (owner == OWN_LS) && mem_rvalid;
    if_rdata  = mem_rdata;
    ls_rdata  = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      owner   <= OWN_LS;
      drop    <= 1'b0;
      streak  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (if_win) begin
        owner   <= OWN_IF;
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        wstrb_q <= '0;
        streak  <= '0;
      end else if (ls_win) begin
        owner   <= OWN_LS;
        addr_q  <= ls_addr;
        we_q    <= ls_we;
        wdata_q <= ls_wdata;
        wstrb_q <= ls_wstrb;
        if (!if_req) begin
          streak <= '0;
        end else if (streak != STREAK_MAX) begin
          streak <= streak + 1'b1;
        end
      end
      if (state_nxt == S_IDLE) begin
        drop <= 1'b0;
      end else if (state != S_IDLE && owner == OWN_IF && if_flush) begin
        drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table-driven transactions, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned MAXS = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req, if_flush, if_gnt, if_rvalid;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
  logic [3:0]      ls_wstrb;
  logic            mem_req, mem_we, mem_ready, mem_rvalid;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_wstrb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.XLEN(XLEN), .MAX_LSU_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wstrb(ls_wstrb), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    bit              use_if;
    bit              we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
    logic [XLEN-1:0] rdata;
    int unsigned     ready_wait;
    int unsigned     resp_wait;
    bit              exp_we;
    logic [3:0]      exp_wstrb;
  } vec_t;

  vec_t vecs[6];
  vec_t v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0; ls_wstrb = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  // Called in the REQ cycle: accept, then respond one cycle later.
  task automatic complete(input logic [31:0] rd, input bit exp_if);
    mem_ready = 1;
    settle();
    chk("cmp_mem_req", mem_req, 1);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = rd;
    settle();
    chk("cmp_if_rvalid", if_rvalid, exp_if);
    chk("cmp_ls_rvalid", ls_rvalid, !exp_if);
    chk("cmp_rdata", exp_if ? if_rdata : ls_rdata, rd);
    tick();
    mem_rvalid = 0;
  endtask

  // Reference model state (transaction level)
  bit              busy, acc, own_if, dropped, if_pend, ls_pend;
  int              lsw;
  logic [XLEN-1:0] e_addr, e_wdata;
  logic            e_we;
  logic [3:0]      e_wstrb;
  bit              ifw, p_if_gnt, p_ls_gnt, p_mreq, p_if_rv, p_ls_rv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 4'hF, 32'hDEAD_BEEF, 0, 0, 1'b0, 4'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 32'h0000_0001, 0, 0, 1'b1, 4'hF};
    vecs[2] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0000_0000, 4'h3, 32'hA5A5_5A5A, 2, 1, 1'b0, 4'h3};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'h0, 32'h0BAD_F00D, 3, 3, 1'b0, 4'h0};
    vecs[4] = '{1'b0, 1'b1, 32'h0000_0FF0, 32'hCAFE_BABE, 4'h5, 32'h0000_0000, 1, 2, 1'b1, 4'h5};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h7777_7777, 4'hA, 32'hFFFF_FFFF, 0, 4, 1'b0, 4'h0};

    do_reset();
    mem_rvalid = 1;
    settle();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_gnts", {if_gnt, ls_gnt}, 0);
    chk("rst_rvalids", {if_rvalid, ls_rvalid}, 0);
    tick();
    mem_rvalid = 0;

    // Table-driven single-requester transactions
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      ls_we = v.we; ls_wdata = v.wdata; ls_wstrb = v.wstrb;
      if (v.use_if) begin if_req = 1; if_addr = v.addr; end
      else begin ls_req = 1; ls_addr = v.addr; end
      settle();
      chk("vec_if_gnt", if_gnt, v.use_if);
      chk("vec_ls_gnt", ls_gnt, !v.use_if);
      tick();
      if_req = 0; ls_req = 0;
      for (int unsigned w = 0; w < v.ready_wait; w++) begin
        settle();
        chk("vec_mem_req_wait", mem_req, 1);
        tick();
      end
      mem_ready = 1;
      settle();
      chk("vec_mem_req", mem_req, 1);
      chk("vec_mem_addr", mem_addr, v.addr);
      chk("vec_mem_we", mem_we, v.exp_we);
      chk("vec_mem_wstrb", mem_wstrb, v.exp_wstrb);
      if (v.exp_we) chk("vec_mem_wdata", mem_wdata, v.wdata);
      tick();
      mem_ready = 0;
      for (int unsigned w = 0; w < v.resp_wait; w++) begin
        settle();
        chk("vec_mem_req_resp", mem_req, 0);
        chk("vec_rvalid_wait", {if_rvalid, ls_rvalid}, 0);
        tick();
      end
      mem_rvalid = 1; mem_rdata = v.rdata;
      settle();
      chk("vec_if_rvalid", if_rvalid, v.use_if);
      chk("vec_ls_rvalid", ls_rvalid, !v.use_if);
      chk("vec_rdata", v.use_if ? if_rdata : ls_rdata, v.rdata);
      tick();
      mem_rvalid = 0;
    end

    // Both requesters rise together: store first, then fetch
    do_reset();
    if_req = 1; if_addr = 32'h100;
    ls_req = 1; ls_we = 1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678; ls_wstrb = 4'hF;
    settle();
    chk("both_ls_gnt", ls_gnt, 1);
    chk("both_if_gnt0", if_gnt, 0);
    tick();
    ls_req = 0;
    settle();
    chk("both_no_gnt_req", if_gnt, 0);
    chk("both_mem_we", mem_we, 1);
    chk("both_mem_wstrb", mem_wstrb, 4'hF);
    chk("both_mem_wdata", mem_wdata, 32'h1234_5678);
    complete(32'h0, 1'b0);
    settle();
    chk("both_if_gnt", if_gnt, 1);
    tick();
    if_req = 0;
    complete(32'h1111_2222, 1'b1);

    // Streak: both held high, order LS x4, IF, LS x4, IF
    do_reset();
    if_req = 1; if_addr = 32'h40; ls_req = 1; ls_addr = 32'h80;
    for (int g = 0; g < 10; g++) begin
      settle();
      chk("streak_if_gnt", if_gnt, (g == 4 || g == 9));
      chk("streak_ls_gnt", ls_gnt, !(g == 4 || g == 9));
      tick();
      mem_ready = 1;
      settle();
      chk("streak_busy_gnt", {if_gnt, ls_gnt}, 0);
      tick();
      mem_ready = 0; mem_rvalid = 1;
      tick();
      mem_rvalid = 0;
    end
    if_req = 0; ls_req = 0;

    // Flush in RESP one cycle before the response
    do_reset();
    if_req = 1; if_addr = 32'h300;
    settle();
    chk("flush_gnt", if_gnt, 1);
    tick();
    if_req = 0; mem_ready = 1;
    tick();
    mem_ready = 0; if_flush = 1;
    settle();
    chk("flush_rvalid_a", if_rvalid, 0);
    tick();
    if_flush = 0; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    settle();
    chk("flush_rvalid_b", if_rvalid, 0);
    tick();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h304;
    settle();
    chk("flush_regnt", if_gnt, 1);
    tick();
    if_req = 0;
    complete(32'h6666_7777, 1'b1);

    // Flush coinciding with the response
    if_req = 1;
    settle();
    chk("flushc_gnt", if_gnt, 1);
    tick();
    if_req = 0; mem_ready = 1;
    tick();
    mem_ready = 0; mem_rvalid = 1; if_flush = 1;
    settle();
    chk("flushc_rvalid", if_rvalid, 0);
    tick();
    mem_rvalid = 0; if_flush = 0;

    // Flushed request in IDLE is not granted
    do_reset();
    if_req = 1; if_flush = 1; if_addr = 32'h400;
    settle();
    chk("idleflush_gnt0", if_gnt, 0);
    tick();
    if_flush = 0;
    settle();
    chk("idleflush_gnt1", if_gnt, 1);
    tick();
    if_req = 0;
    complete(32'h1234_0000, 1'b1);

    // Reset mid-transaction, late response ignored
    do_reset();
    if_req = 1; if_addr = 32'h500;
    tick();
    if_req = 0;
    settle();
    chk("rstmid_mem_req1", mem_req, 1);
    rst = 1;
    tick();
    rst = 0;
    settle();
    chk("rstmid_mem_req0", mem_req, 0);
    tick();
    mem_rvalid = 1;
    settle();
    chk("rstmid_if_rvalid", if_rvalid, 0);
    chk("rstmid_ls_rvalid", ls_rvalid, 0);
    tick();
    mem_rvalid = 0;

    // Randomized traffic against the reference model
    do_reset();
    busy = 0; acc = 0; own_if = 0; dropped = 0; lsw = 0; if_pend = 0; ls_pend = 0;
    e_addr = '0; e_wdata = '0; e_we = 0; e_wstrb = '0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (!if_pend && $urandom_range(2) == 0) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!ls_pend && $urandom_range(2) == 0) begin
        ls_pend = 1; ls_we = 1'($urandom_range(1)); ls_addr = $urandom;
        ls_wdata = $urandom; ls_wstrb = 4'($urandom);
      end
      if_req = if_pend; ls_req = ls_pend;
      if_flush = ($urandom_range(7) == 0);
      mem_rdata = $urandom;
      if (busy && acc) mem_rvalid = 1'($urandom_range(1));
      else if (!busy)  mem_rvalid = ($urandom_range(5) == 0);
      else             mem_rvalid = 0;
      mem_ready = mem_rvalid ? 1'b0 : 1'($urandom_range(1));
      settle();

      ifw      = if_req && !if_flush;
      p_if_gnt = !busy && ifw && (lsw == MAXS || !ls_req);
      p_ls_gnt = !busy && ls_req && !p_if_gnt;
      p_mreq   = busy && !acc;
      p_if_rv  = busy && acc && own_if && mem_rvalid && !dropped && !if_flush;
      p_ls_rv  = busy && acc && !own_if && mem_rvalid;
      chk("rnd_if_gnt", if_gnt, p_if_gnt);
      chk("rnd_ls_gnt", ls_gnt, p_ls_gnt);
      chk("rnd_mem_req", mem_req, p_mreq);
      chk("rnd_if_rvalid", if_rvalid, p_if_rv);
      chk("rnd_ls_rvalid", ls_rvalid, p_ls_rv);
      if (p_mreq) begin
        chk("rnd_mem_addr", mem_addr, e_addr);
        chk("rnd_mem_we", mem_we, e_we);
        chk("rnd_mem_wstrb", mem_wstrb, e_wstrb);
        if (e_we) chk("rnd_mem_wdata", mem_wdata, e_wdata);
      end
      if (p_if_rv) chk("rnd_if_rdata", if_rdata, mem_rdata);
      if (p_ls_rv) chk("rnd_ls_rdata", ls_rdata, mem_rdata);

      if (busy && acc && mem_rvalid) begin
        busy = 0;
      end else if (busy) begin
        if (!acc && mem_ready) acc = 1;
        if (own_if && if_flush) dropped = 1;
      end
      if (p_if_gnt) begin
        busy = 1; acc = 0; own_if = 1; dropped = 0; lsw = 0; if_pend = 0;
        e_addr = if_addr; e_we = 0; e_wstrb = 0; e_wdata = '0;
      end
      if (p_ls_gnt) begin
        busy = 1; acc = 0; own_if = 0; dropped = 0; ls_pend = 0;
        e_addr = ls_addr; e_we = ls_we; e_wstrb = ls_wstrb; e_wdata = ls_wdata;
        lsw = if_req ? ((lsw < MAXS) ? lsw + 1 : MAXS) : 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
